// File: rtl/aes128_package.sv
// Shared constants and helpers for the masked AES-128 datapath: per-stage HPC3
// randomness budgets of the 3-stage GF(2^8) inverse and a ceiling-log2 helper.
package aes128_package;

  function automatic int unsigned hpc3_share_pairs(input int unsigned num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

  // Stage 1: one GF(2^4) HPC3 product, 2 fresh bits per share pair and product bit.
  function automatic int unsigned stage_1_hpc3_randoms(input int unsigned num_shares);
    return 8 * hpc3_share_pairs(num_shares);
  endfunction

  function automatic int unsigned stage_2_hpc3_randoms(input int unsigned num_shares);
    return 4 * hpc3_share_pairs(num_shares);
  endfunction

  // Stage 3: two parallel GF(2^4) HPC3 products.
  function automatic int unsigned stage_3_hpc3_randoms(input int unsigned num_shares);
    return 16 * hpc3_share_pairs(num_shares);
  endfunction

  function automatic int unsigned clog2_ceil(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/masked_rand_beat_buffer.sv
// Packs PRNG beats into one randomness set; reports FULL and clears on consume,
// optionally refilling slot 0 in the same cycle.
module masked_rand_beat_buffer
  import aes128_package::*;
#(
  parameter int unsigned RAND_BEAT = 32,
  parameter int unsigned N_BEATS   = 1,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = clog2_ceil(N_BEATS + 1)
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_flush,
  input  logic                 in_xfer,
  input  logic                 in_consume,
  input  logic [RAND_BEAT-1:0] in_rand,
  output logic                 out_full,
  output logic [DATA_W-1:0]    out_data
);

  localparam int unsigned BUF_W = N_BEATS * RAND_BEAT;

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_base;
  logic [CNT_W-1:0]  w_count_d;
  logic [DATA_W-1:0] r_buf;
  logic [BUF_W-1:0]  w_buf_base;
  logic [BUF_W-1:0]  w_buf_next;
  logic              w_unused_hi;

  // A transfer is only offered while a slot is free, so the write never runs past the buffer.
  always_comb begin
    w_count_base             = in_consume ? '0 : r_count;
    w_buf_base               = '0;
    w_buf_base[DATA_W-1:0]   = in_consume ? '0 : r_buf;
    w_buf_next               = w_buf_base;
    if (in_xfer) begin
      w_buf_next[int'(w_count_base) * RAND_BEAT +: RAND_BEAT] = in_rand;
    end
    w_count_d = w_count_base + CNT_W'(in_xfer);
  end

  // Beat bits beyond DATA_W are dropped here.
  assign w_unused_hi = ^w_buf_next;

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_count <= '0;
      r_buf   <= '0;
    end else if (in_flush) begin
      r_count <= '0;
      r_buf   <= '0;
    end else begin
      r_count <= w_count_d;
      r_buf   <= w_buf_next[DATA_W-1:0];
    end
  end

  assign out_full = (r_count == CNT_W'(N_BEATS));
  assign out_data = r_buf;

endmodule

// File: rtl/masked_3stage_inv_rand_seq.sv
// Sequencer for the masked 3-stage GF(2^8) inverse: admits an operation only with a full
// randomness set and hands each stage its slice in the cycle that stage consumes it.
module masked_3stage_inv_rand_seq
  import aes128_package::*;
#(
  parameter int unsigned NUM_SHARES = 2,
  parameter int unsigned R1         = stage_1_hpc3_randoms(NUM_SHARES),
  parameter int unsigned R2         = stage_2_hpc3_randoms(NUM_SHARES),
  parameter int unsigned R3         = stage_3_hpc3_randoms(NUM_SHARES),
  parameter int unsigned RAND_BEAT  = 32
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_valid,
  output logic                 out_ready,
  input  logic [RAND_BEAT-1:0] in_rand,
  input  logic                 in_rand_valid,
  output logic                 out_rand_ready,
  input  logic                 in_flush,
  output logic [R1-1:0]        out_random_s1,
  output logic [R2-1:0]        out_random_s2,
  output logic [R3-1:0]        out_random_s3,
  output logic                 out_valid_t1,
  output logic                 out_valid_t2,
  output logic                 out_valid_t3
);

  localparam int unsigned R_TOTAL    = R1 + R2 + R3;
  localparam int unsigned N_BEATS    = (R_TOTAL + RAND_BEAT - 1) / RAND_BEAT;
  localparam int unsigned BEAT_CNT_W = clog2_ceil(N_BEATS + 1);

  logic               w_full;
  logic               w_fire;
  logic               w_xfer;
  logic [R_TOTAL-1:0] w_data;
  logic [2:0]         r_valid;
  logic [R2-1:0]      r_s2;
  logic [R3-1:0]      r_s3_hold;
  logic [R3-1:0]      r_s3;

  assign out_ready      = w_full & ~in_flush;
  assign w_fire         = in_valid & out_ready;
  assign out_rand_ready = ~in_flush & (~w_full | w_fire);
  assign w_xfer         = in_rand_valid & out_rand_ready;

  masked_rand_beat_buffer #(
    .RAND_BEAT (RAND_BEAT),
    .N_BEATS   (N_BEATS),
    .DATA_W    (R_TOTAL),
    .CNT_W     (BEAT_CNT_W)
  ) u_beat_buffer (
    .in_clock   (in_clock),
    .in_reset   (in_reset),
    .in_flush   (in_flush),
    .in_xfer    (w_xfer),
    .in_consume (w_fire),
    .in_rand    (in_rand),
    .out_full   (w_full),
    .out_data   (w_data)
  );

  // Slice registers load zero when idle so no stale random bits ever reach a stage.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_valid   <= '0;
      r_s2      <= '0;
      r_s3_hold <= '0;
      r_s3      <= '0;
    end else if (in_flush) begin
      r_valid   <= '0;
      r_s2      <= '0;
      r_s3_hold <= '0;
      r_s3      <= '0;
    end else begin
      r_valid   <= {r_valid[1:0], w_fire};
      r_s2      <= w_fire ? w_data[R1+R2-1:R1] : '0;
      r_s3_hold <= w_fire ? w_data[R_TOTAL-1:R1+R2] : '0;
      r_s3      <= r_s3_hold;
    end
  end

  assign out_random_s1 = w_fire ? w_data[R1-1:0] : '0;

  // A flush kills in-flight operations in the flush cycle itself, not one cycle later.
  assign out_random_s2 = in_flush ? '0 : r_s2;
  assign out_random_s3 = in_flush ? '0 : r_s3;
  assign out_valid_t1  = r_valid[0] & ~in_flush;
  assign out_valid_t2  = r_valid[1] & ~in_flush;
  assign out_valid_t3  = r_valid[2] & ~in_flush;

endmodule

// File: tb/tb_masked_3stage_inv_rand_seq.sv
// Directed bench for the randomness sequencer with a queue-based reference model
// checked every cycle, plus hand-computed pins.
module tb_masked_3stage_inv_rand_seq;

  localparam int unsigned R1 = 4;
  localparam int unsigned R2 = 8;
  localparam int unsigned R3 = 4;
  localparam int unsigned RB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_rand_valid = 1'b0;
  logic          in_flush = 1'b0;
  logic [RB-1:0] in_rand = '0;
  logic          out_ready;
  logic          out_rand_ready;
  logic [R1-1:0] out_random_s1;
  logic [R2-1:0] out_random_s2;
  logic [R3-1:0] out_random_s3;
  logic          out_valid_t1;
  logic          out_valid_t2;
  logic          out_valid_t3;

  always #5 clk = ~clk;

  masked_3stage_inv_rand_seq #(
    .NUM_SHARES (2),
    .R1         (R1),
    .R2         (R2),
    .R3         (R3),
    .RAND_BEAT  (RB)
  ) dut (
    .in_clock       (clk),
    .in_reset       (rst_n),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_rand        (in_rand),
    .in_rand_valid  (in_rand_valid),
    .out_rand_ready (out_rand_ready),
    .in_flush       (in_flush),
    .out_random_s1  (out_random_s1),
    .out_random_s2  (out_random_s2),
    .out_random_s3  (out_random_s3),
    .out_valid_t1   (out_valid_t1),
    .out_valid_t2   (out_valid_t2),
    .out_valid_t3   (out_valid_t3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: held beats in a queue, issued operations tagged with their fire cycle.
  typedef struct {
    int          fc;
    logic [15:0] val;
  } op_t;

  logic [7:0] q[$];
  op_t        ops[$];
  int         cyc = 0;

  always @(negedge clk) begin : model
    logic [15:0] v;
    logic [31:0] e_s1, e_s2, e_s3;
    bit          fl, rdy, fire, rrdy, xfer, ev1, ev2, ev3;
    int          age;
    if (!rst_n) begin
      q.delete();
      ops.delete();
      chk("rst_ready", out_ready, 0);
      chk("rst_rand_ready", out_rand_ready, !in_flush);
      chk("rst_valids", {out_valid_t1, out_valid_t2, out_valid_t3}, 0);
      chk("rst_randoms", {out_random_s1, out_random_s2, out_random_s3}, 0);
    end else begin
      fl   = in_flush;
      rdy  = (q.size() == 2) && !fl;
      fire = in_valid && rdy;
      rrdy = !fl && ((q.size() < 2) || fire);
      xfer = in_rand_valid && rrdy;
      v    = (q.size() == 2) ? {q[1], q[0]} : 16'h0;
      e_s1 = fire ? 32'(v[3:0]) : 32'h0;
      e_s2 = 0;
      e_s3 = 0;
      ev1  = 0;
      ev2  = 0;
      ev3  = 0;
      if (!fl) begin
        foreach (ops[i]) begin
          age = cyc - ops[i].fc;
          if (age == 1) begin
            ev1  = 1;
            e_s2 = 32'(ops[i].val[11:4]);
          end else if (age == 2) begin
            ev2  = 1;
            e_s3 = 32'(ops[i].val[15:12]);
          end else if (age == 3) begin
            ev3 = 1;
          end
        end
      end
      chk("ready", out_ready, rdy);
      chk("rand_ready", out_rand_ready, rrdy);
      chk("s1", out_random_s1, e_s1);
      chk("s2", out_random_s2, e_s2);
      chk("s3", out_random_s3, e_s3);
      chk("valid_t1", out_valid_t1, ev1);
      chk("valid_t2", out_valid_t2, ev2);
      chk("valid_t3", out_valid_t3, ev3);
      if (fl) begin
        q.delete();
        ops.delete();
      end else begin
        if (fire) begin
          ops.push_back('{fc: cyc, val: v});
          q.delete();
        end
        if (xfer) q.push_back(in_rand);
      end
    end
    cyc++;
    while (ops.size() > 0 && (cyc - ops[0].fc) > 3) void'(ops.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    repeat (2) @(posedge clk);
    mid();
    chk("pin_reset_ready", out_ready, 0);
    chk("pin_reset_rand_ready", out_rand_ready, 1);
    tick();
    rst_n = 1'b1;

    // Two beats then a fire: buffer 0x3CA5 -> s1=5, s2=CA, s3=3.
    in_valid = 1; in_rand_valid = 1; in_rand = 8'hA5;
    mid(); chk("pin_t1_ready_b0", out_ready, 0);
    tick();
    in_rand = 8'h3C;
    mid(); chk("pin_t1_ready_b1", out_ready, 0);
    tick();
    in_rand_valid = 0;
    mid(); chk("pin_t1_ready", out_ready, 1); chk("pin_t1_s1", out_random_s1, 4'h5);
    tick();
    in_valid = 0;
    mid(); chk("pin_t1_s2", out_random_s2, 8'hCA); chk("pin_t1_v1", out_valid_t1, 1);
    tick();
    mid(); chk("pin_t1_s3", out_random_s3, 4'h3); chk("pin_t1_v3_early", out_valid_t3, 0);
    tick();
    mid(); chk("pin_t1_v3", out_valid_t3, 1); chk("pin_t1_s3_clear", out_random_s3, 0);
    tick();
    mid(); chk("pin_t1_v3_once", out_valid_t3, 0);

    // Starvation.
    tick();
    in_valid = 1;
    repeat (20) tick();
    mid(); chk("pin_starve_ready", out_ready, 0); chk("pin_starve_v3", out_valid_t3, 0);

    // Continuous beats: a fire every second cycle, refill lands in slot 0.
    tick();
    in_rand_valid = 1;
    for (int i = 0; i < 8; i++) begin
      b = 8'h11;
      in_rand = 8'(b * 8'(i + 1));
      mid();
      if (i == 2) chk("pin_cont_s1_a", out_random_s1, 4'h1);
      if (i == 3) chk("pin_cont_s2_a", out_random_s2, 8'h21);
      if (i == 4) begin
        chk("pin_cont_s1_b", out_random_s1, 4'h3);
        chk("pin_cont_rrdy_fire", out_rand_ready, 1);
        chk("pin_cont_s3_a", out_random_s3, 4'h2);
      end
      if (i == 5) chk("pin_cont_s2_b", out_random_s2, 8'h43);
      tick();
    end

    // Fire, then flush in the next cycle while a beat is offered.
    in_rand_valid = 0;
    mid(); chk("pin_fl_ready", out_ready, 1); chk("pin_fl_s1", out_random_s1, 4'h7);
    tick();
    in_flush = 1; in_rand_valid = 1; in_rand = 8'h99;
    mid();
    chk("pin_fl_rrdy", out_rand_ready, 0); chk("pin_fl_v1", out_valid_t1, 0);
    chk("pin_fl_s2", out_random_s2, 0);
    tick();
    in_flush = 0; in_rand_valid = 0; in_valid = 0;
    mid(); chk("pin_fl_v2", out_valid_t2, 0);
    tick();
    mid(); chk("pin_fl_v3", out_valid_t3, 0);
    tick();
    in_rand = 8'hAB; in_rand_valid = 1; in_valid = 1;
    tick();
    in_rand_valid = 0;
    mid(); chk("pin_fl_one_beat", out_ready, 0);
    tick();
    in_rand = 8'hCD; in_rand_valid = 1;
    tick();
    in_rand_valid = 0;
    mid(); chk("pin_fl_refire", out_ready, 1); chk("pin_fl_refire_s1", out_random_s1, 4'hB);
    tick();
    in_valid = 0;
    mid(); chk("pin_rst_v1", out_valid_t1, 1);
    tick();
    mid(); chk("pin_rst_v2_pre", out_valid_t2, 1);

    // Async reset with stage 2 live.
    rst_n = 0;
    #1;
    chk("pin_rst_v", {out_valid_t1, out_valid_t2, out_valid_t3}, 0);
    chk("pin_rst_rand", {out_random_s1, out_random_s2, out_random_s3}, 0);
    chk("pin_rst_ready", out_ready, 0);
    tick();
    tick();
    rst_n = 1;
    in_valid = 1; in_rand_valid = 1; in_rand = 8'h5A;
    mid(); chk("pin_post_rst_0", out_ready, 0);
    tick();
    in_rand = 8'hC3;
    mid(); chk("pin_post_rst_1", out_ready, 0);
    tick();
    in_rand_valid = 0;
    mid(); chk("pin_post_rst_fire", out_ready, 1); chk("pin_post_rst_s1", out_random_s1, 4'hA);
    tick();
    in_valid = 0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/masked_3stage_inv_rand_seq.md
Name: masked_3stage_inv_rand_seq

Overview:
- Sequencer and randomness scheduler for the masked 3-stage GF(2^8) inverse pipeline (stage 1 -> stage 2 HPC3 -> stage 3).
- Collects fresh randomness beats from the PRNG stream into a per-operation buffer and admits a new inversion only when a full randomness set is held.
- Delivers each stage's random slice in the exact cycle that stage consumes it, and tracks per-stage valid flags through the fixed 3-cycle datapath.
- The datapath has no backpressure. The sequencer is the only point where operations stall.

Parameters:
- NUM_SHARES, 2, share count forwarded to the package randomness functions.
- R1, stage_1_hpc3_randoms(NUM_SHARES), random bits consumed by stage 1.
- R2, stage_2_hpc3_randoms(NUM_SHARES), random bits consumed by stage 2.
- R3, stage_3_hpc3_randoms(NUM_SHARES), random bits consumed by stage 3.
- RAND_BEAT, 32, bits per PRNG beat.
- (localparam) R_TOTAL = R1+R2+R3; N_BEATS = ceil(R_TOTAL/RAND_BEAT); BEAT_CNT_W = clog2(N_BEATS+1).

Ports:
- in_clock  input  1  clock; all state updates on rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  requester offers an operand to stage 1 this cycle.
- out_ready  output  1  operation accepted; handshake fires when in_valid && out_ready.
- in_rand  input  RAND_BEAT  PRNG beat data.
- in_rand_valid  input  1  PRNG beat present.
- out_rand_ready  output  1  sequencer takes the beat; transfer when both high.
- in_flush  input  1  synchronous flush.
- out_random_s1  output  R1  stage-1 randomness.
- out_random_s2  output  R2  stage-2 randomness.
- out_random_s3  output  R3  stage-3 randomness.
- out_valid_t1  output  1  stage-1 register holds a live operation.
- out_valid_t2  output  1  stage-2 register holds a live operation.
- out_valid_t3  output  1  stage-3 register holds a live operation (result valid).

Behaviour:
- Reset (async assert, deassert synchronous to in_clock):
  - beat counter = 0, buffer = 0, all valid flags = 0, all stage random registers = 0.
  - out_ready = 0 and out_rand_ready = 1 until the first edge after deassertion.
- Buffer fill:
  - Beat k (0-based) is written to buffer[k*RAND_BEAT +: RAND_BEAT].
  - Buffer bits at R_TOTAL and above are discarded.
  - FULL = (count == N_BEATS).
  - out_rand_ready = !FULL || fire, where fire = in_valid && out_ready. A beat may be accepted in the same cycle the buffer is consumed.
- Admission: out_ready = FULL && !in_flush. This is combinational and does not depend on in_valid.
- Slice mapping at fire: s1 = buffer[R1-1:0], s2 = buffer[R1+R2-1:R1], s3 = buffer[R_TOTAL-1:R1+R2].
- Fire cycle (cycle 0):
  - out_random_s1 = s1 combinationally in the fire cycle. Stage 1 samples its randomness together with its operand.
  - s2 and s3 are registered into a holding pipe.
  - out_random_s2 = s2 in cycle 1; out_random_s3 = s3 in cycle 2.
  - The valid shift register gives out_valid_t1 in cycle 1, t2 in cycle 2, t3 in cycle 3. Fixed latency 3.
- Consume: on fire, buffer is zeroed and count goes to 0. If a beat transfers in the same cycle, count goes to 1 and that beat lands in slot 0.
- Freshness: every PRNG bit is used at most once.
  - out_random_s1 = 0 when there is no fire.
  - out_random_s2 and out_random_s3 = 0 in any cycle whose stage slot is not live.
- Back-to-back operations: with N_BEATS = 1 and in_rand_valid held high, one fire per cycle is sustained.
- Starvation: in_valid high while !FULL means no fire. The requester holds its operand; no timeout.
- Flush (sync, highest priority below reset):
  - Clears count, buffer, valid flags and stage random registers.
  - out_ready = 0 and out_rand_ready = 0 in the flush cycle. A beat offered in that cycle is not taken.
- Reset mid-operation: in-flight operations are lost, and out_valid_t* drop immediately on the asynchronous assert.

Decomposition:
- aes128_package gains:
  - functions stage_1_hpc3_randoms and stage_3_hpc3_randoms, alongside the existing stage_2_hpc3_randoms;
  - a clog2-style helper for BEAT_CNT_W.
- One sub-module: masked_rand_beat_buffer, covering the beat counter, packing and FULL/consume logic, parameterized by RAND_BEAT and N_BEATS.
- Slice delay and valid shift stay in the top module.

Test Plan (override R1=4, R2=8, R3=4, RAND_BEAT=8, so N_BEATS=2):
- Reset then beats 0xA5, 0x3C with in_valid=1 -> out_ready first high in the cycle after the 2nd beat. At fire: s1=0x5; cycle 1: s2=0xCA; cycle 2: s3=0x3; out_valid_t3 high in cycle 3 only.
- in_valid=1 with no in_rand_valid for 20 cycles -> out_ready=0 throughout, all valids 0, all random outputs 0.
- Continuous beats with in_valid=1 -> one fire every 2 cycles. Each beat value appears exactly once across the outputs; outputs are 0 in unused slots.
- Fire in cycle 5 with a beat transfer in the same cycle -> count=1 after the edge, and the new beat occupies bits [7:0] of the next set.
- in_flush asserted the cycle after a fire -> out_valid_t1..t3 never assert for that operation, count=0, and a beat offered during flush is not accepted.
- Async reset asserted mid-cycle while out_valid_t2=1 -> all outputs 0 immediately. After release, no operation fires until 2 fresh beats arrive.
